// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode.
// Buffers {PC+4, instruction} pairs and presents the oldest entry as the IF/ID payload.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        in_instruction,
    input  logic [31:0]        in_incremented_pc,
    output logic               in_ready,
    input  logic               in_flush,
    input  logic               in_stall,
    output logic               out_valid,
    output logic [31:0]        out_instruction,
    output logic [31:0]        out_incremented_pc,
    output logic [PTR_W:0]     out_count,
    output logic [15:0]        out_stall_cycles
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [15:0]      stall_cycles;
    logic             push;
    logic             pop;

    // Ready and valid come only from the registered count, so there is no
    // combinational path from flush or stall back to fetch.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~in_flush;
    assign pop       = out_valid & ~in_stall & ~in_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (in_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {in_incremented_pc, in_instruction};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (in_stall && out_valid && !in_flush && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    always_comb begin
        out_instruction    = 32'h0;
        out_incremented_pc = 32'h0;
        if (out_valid) begin
            out_incremented_pc = mem[head][63:32];
            out_instruction    = mem[head][31:0];
        end
    end

    assign out_count        = count;
    assign out_stall_cycles = stall_cycles;

endmodule
